// File: rtl/pump_driver.sv
// pump_driver: converts the level controller's raw pump requests into safe
// pump drives. Provides mutual exclusion, a minimum run time, a dead time
// between pumps, an emergency stop and a sticky request-conflict flag.
module pump_driver #(
  parameter int unsigned MIN_ON_CYCLES = 1000,
  parameter int unsigned DEAD_CYCLES   = 100,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       pump1_req,
  input  logic       pump2_req,
  input  logic       estop,
  output logic       pump1_drv,
  output logic       pump2_drv,
  output logic [1:0] state,
  output logic       conflict
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_DRAIN = 2'b10,
    S_DEAD  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             req_fill;
  logic             req_drain;
  logic             min_done;

  // Both requests high together decode to "no request".
  assign req_fill  = pump1_req & ~pump2_req;
  assign req_drain = pump2_req & ~pump1_req;
  assign min_done  = (cnt >= MIN_LAST);
  assign state     = state_q;

  // Next-state decode; every pump stop goes through DEAD, then IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!estop) begin
          if (req_fill)       state_d = S_FILL;
          else if (req_drain) state_d = S_DRAIN;
        end
      end
      S_FILL: begin
        if (estop || (!req_fill && min_done))  state_d = S_DEAD;
      end
      S_DRAIN: begin
        if (estop || (!req_drain && min_done)) state_d = S_DEAD;
      end
      S_DEAD: begin
        if (!estop && (cnt == DEAD_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; drives are registered from the next state so they
  // always match the visible state in the same cycle.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pump1_drv <= 1'b0;
      pump2_drv <= 1'b0;
    end else begin
      state_q   <= state_d;
      pump1_drv <= (state_d == S_FILL);
      pump2_drv <= (state_d == S_DRAIN);
    end
  end

  // Shared state-duration counter: cleared on every state entry, held at 0
  // in DEAD while estop is high, saturating otherwise.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_d != state_q) begin
      cnt <= '0;
    end else if ((state_q == S_DEAD) && estop) begin
      cnt <= '0;
    end else if ((state_q != S_IDLE) && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) conflict <= 1'b0;
    else if (pump1_req && pump2_req) conflict <= 1'b1;
  end

endmodule

// File: tb/tb_pump_driver.sv
// tb_pump_driver: table-driven directed checks of pump_driver with
// MIN_ON_CYCLES=4 and DEAD_CYCLES=3, plus hand-written estop/reset sequences.
module tb_pump_driver;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] FILL  = 2'b01;
  localparam logic [1:0] DRAIN = 2'b10;
  localparam logic [1:0] DEAD  = 2'b11;

  logic       CLK100MHZ = 1'b0;
  logic       rst       = 1'b1;
  logic       pump1_req = 1'b0;
  logic       pump2_req = 1'b0;
  logic       estop     = 1'b0;
  logic       pump1_drv;
  logic       pump2_drv;
  logic [1:0] state;
  logic       conflict;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  typedef struct packed {
    logic       rst;
    logic       p1;
    logic       p2;
    logic       es;
    logic [1:0] st;
    logic       d1;
    logic       d2;
    logic       cf;
  } vec_t;

  vec_t tbl[$];

  pump_driver #(
    .MIN_ON_CYCLES(4),
    .DEAD_CYCLES  (3),
    .CNT_W        (16)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .pump1_req(pump1_req),
    .pump2_req(pump2_req),
    .estop    (estop),
    .pump1_drv(pump1_drv),
    .pump2_drv(pump2_drv),
    .state    (state),
    .conflict (conflict)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  function automatic vec_t mk(input logic r, input logic a, input logic b,
                              input logic e, input logic [1:0] st,
                              input logic d1, input logic d2, input logic cf);
    vec_t v;
    v.rst = r; v.p1 = a; v.p2 = b; v.es = e;
    v.st = st; v.d1 = d1; v.d2 = d2; v.cf = cf;
    return v;
  endfunction

  // Apply inputs, advance one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic a, input logic b, input logic e);
    rst = r; pump1_req = a; pump2_req = b; estop = e;
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] st,
                       input logic d1, input logic d2, input logic cf);
    n_total++;
    if ({state, pump1_drv, pump2_drv, conflict} !== {st, d1, d2, cf})
      $display("FAIL %s: got state=%b p1_drv=%b p2_drv=%b conflict=%b, expected state=%b p1_drv=%b p2_drv=%b conflict=%b",
               nm, state, pump1_drv, pump2_drv, conflict, st, d1, d2, cf);
    else
      n_passed++;
    n_total++;
    if ((pump1_drv & pump2_drv) !== 1'b0)
      $display("FAIL %s exclusion: got p1_drv=%b p2_drv=%b, expected not both high",
               nm, pump1_drv, pump2_drv);
    else
      n_passed++;
  endtask

  initial begin
    int unsigned waited;

    // Reset with both requests high, then conflict sets and IDLE holds.
    repeat (2) tbl.push_back(mk(1, 1, 1, 0, IDLE, 0, 0, 0));
    repeat (5) tbl.push_back(mk(0, 1, 1, 0, IDLE, 0, 0, 1));
    repeat (2) tbl.push_back(mk(0, 0, 0, 0, IDLE, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, IDLE, 0, 0, 0));
    // One-cycle fill request: 4 cycles FILL, 3 DEAD, then IDLE.
    tbl.push_back(mk(0, 1, 0, 0, FILL, 1, 0, 0));
    repeat (3) tbl.push_back(mk(0, 0, 0, 0, FILL, 1, 0, 0));
    repeat (3) tbl.push_back(mk(0, 0, 0, 0, DEAD, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, IDLE, 0, 0, 0));
    // Changeover fill -> drain through DEAD and IDLE.
    repeat (10) tbl.push_back(mk(0, 1, 0, 0, FILL, 1, 0, 0));
    repeat (3) tbl.push_back(mk(0, 0, 1, 0, DEAD, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, IDLE, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, DRAIN, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].p1, tbl[i].p2, tbl[i].es);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].d1, tbl[i].d2, tbl[i].cf);
    end

    // Estop for 5 cycles in DRAIN with cnt=1, drain request kept high.
    step(0, 0, 1, 0); check("drain_cnt1", DRAIN, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1); check($sformatf("estop_hold%0d", i), DEAD, 0, 0, 0);
    end
    step(0, 0, 1, 0); check("estop_rel0", DEAD, 0, 0, 0);
    step(0, 0, 1, 0); check("estop_rel1", DEAD, 0, 0, 0);
    step(0, 0, 1, 0); check("estop_idle", IDLE, 0, 0, 0);
    step(0, 0, 1, 0); check("estop_redrain", DRAIN, 0, 1, 0);

    // Estop right after entry ignores the minimum run time.
    step(0, 0, 0, 1); check("estop_early", DEAD, 0, 0, 0);
    step(0, 0, 0, 0); check("early_dead1", DEAD, 0, 0, 0);
    step(0, 0, 0, 0); check("early_dead2", DEAD, 0, 0, 0);
    step(0, 0, 0, 0); check("early_idle", IDLE, 0, 0, 0);

    // Estop in IDLE blocks a start.
    step(0, 1, 0, 1); check("estop_idle_block", IDLE, 0, 0, 0);
    step(0, 1, 0, 0); check("fill_start", FILL, 1, 0, 0);
    step(0, 1, 0, 0); check("fill_run", FILL, 1, 0, 0);

    // Reset mid-run, then FILL re-entered at the first edge after rst.
    step(1, 1, 0, 0); check("rst_midrun", IDLE, 0, 0, 0);
    step(0, 1, 0, 0); check("fill_reenter", FILL, 1, 0, 0);

    // Conflict during estop still sets the flag.
    step(0, 1, 1, 1); check("conflict_estop", DEAD, 0, 0, 1);
    step(0, 0, 0, 0); check("conflict_sticky", DEAD, 0, 0, 1);

    // Bounded wait for IDLE; it should take exactly 2 more edges.
    waited = 0;
    while (state !== IDLE && waited < 10) begin
      step(0, 0, 0, 0);
      waited++;
    end
    n_total++;
    if (waited != 2)
      $display("FAIL dead_to_idle: got %0d edges, expected 2", waited);
    else
      n_passed++;
    check("final_idle", IDLE, 0, 0, 1);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
